// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path:
// opcodes, ALU function codes, FSM states and the instruction decoder.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110
    } alu_func_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [1:0] {
        K_ALU,
        K_LOAD,
        K_STORE,
        K_BRANCH
    } kind_e;

    typedef struct packed {
        logic      legal;
        kind_e     kind;
        alu_func_e func;
        logic      b_sel;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t       d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ok3;
        logic       shift;
        alu_func_e  base;

        opc   = ir[6:0];
        f7    = ir[31:25];
        f3    = ir[14:12];
        shift = (f3 == F3_SLL) || (f3 == F3_SR);
        ok3   = 1'b1;
        base  = ALU_ADD;
        unique case (f3)
            F3_ADD:  base = ALU_ADD;
            F3_SLL:  base = ALU_SLL;
            F3_XOR:  base = ALU_XOR;
            F3_SR:   base = ALU_SRL;
            F3_OR:   base = ALU_OR;
            F3_AND:  base = ALU_AND;
            default: ok3  = 1'b0;
        endcase

        d = '{legal: 1'b0, kind: K_ALU, func: ALU_ADD, b_sel: 1'b0};
        unique case (opc)
            OP_R: begin
                d.legal = ok3 && ((f7 == F7_ZERO) ||
                          ((f7 == F7_ALT) && (f3 == F3_ADD)));
                d.func  = (f7 == F7_ALT) ? ALU_SUB : base;
            end
            OP_I: begin
                // Shift-immediates with funct7 != 0 (SRAI etc.) are rejected
                d.legal = ok3 && (!shift || (f7 == F7_ZERO));
                d.func  = base;
                d.b_sel = 1'b1;
            end
            OP_LOAD: begin
                d.legal = (f3 == F3_LW);
                d.kind  = K_LOAD;
                d.b_sel = 1'b1;
            end
            OP_STORE: begin
                d.legal = (f3 == F3_LW);
                d.kind  = K_STORE;
                d.b_sel = 1'b1;
            end
            OP_BRANCH: begin
                d.legal = (f3 == F3_BEQ) || (f3 == F3_BNE);
                d.kind  = K_BRANCH;
                d.func  = ALU_SUB;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign/zero-extends the immediate field of the
// instruction register according to its format.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    logic [2:0] f3;
    logic       shift;

    assign f3    = ir[14:12];
    assign shift = (f3 == F3_SLL) || (f3 == F3_SR);

    always_comb begin
        imm = '0;
        unique case (ir[6:0])
            OP_I: begin
                if (shift) imm = {27'd0, ir[24:20]};
                else       imm = {{20{ir[31]}}, ir[31:20]};
            end
            OP_LOAD:   imm = {{20{ir[31]}}, ir[31:20]};
            OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7],
                              ir[30:25], ir[11:8], 1'b0};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl_fsm.sv
// Multi-cycle control FSM for the non-pipelined core: fetch, decode,
// ALU sequencing, data memory access and register writeback.
module exec_ctrl_fsm
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            alu_en,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_func,
    output logic            alu_b_sel,
    output logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_y,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic            rf_we,
    output logic            rf_wsel,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    input  logic            dmem_ack,
    output logic            illegal,
    output logic [XLEN-1:0] pc
);

    state_e          state;
    kind_e           kind_q;
    dec_t            dec;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] imm_dec;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_branch;
    logic            br_take;

    imm_gen u_imm_gen (
        .ir  (ir),
        .imm (imm_dec)
    );

    assign dec       = decode(ir);
    assign rs1_addr  = ir[19:15];
    assign rs2_addr  = ir[24:20];
    assign rd_addr   = ir[11:7];
    assign imem_addr = pc;
    assign dmem_addr = res_q;
    assign pc_plus4  = pc + 32'd4;
    assign pc_branch = pc + imm;

    // funct3[0] separates BNE from BEQ
    assign br_take = ir[12] ? (alu_y != '0) : (alu_y == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            kind_q     <= K_ALU;
            pc         <= RESET_PC;
            ir         <= '0;
            res_q      <= '0;
            imem_req   <= 1'b0;
            alu_en     <= 1'b0;
            alu_opcode <= '0;
            alu_func   <= ALU_ADD;
            alu_b_sel  <= 1'b0;
            imm        <= '0;
            rf_we      <= 1'b0;
            rf_wsel    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec.legal) begin
                        illegal  <= 1'b1;
                        pc       <= pc_plus4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        alu_opcode <= ir[6:0];
                        alu_func   <= dec.func;
                        alu_b_sel  <= dec.b_sel;
                        imm        <= imm_dec;
                        kind_q     <= dec.kind;
                        alu_en     <= 1'b1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_en <= 1'b0;
                    res_q  <= alu_y;
                    unique case (kind_q)
                        K_ALU: begin
                            rf_we   <= (rd_addr != 5'd0);
                            rf_wsel <= 1'b0;
                            state   <= S_WB;
                        end
                        K_LOAD, K_STORE: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (kind_q == K_STORE);
                            state    <= S_MEM;
                        end
                        K_BRANCH: begin
                            pc       <= br_take ? pc_branch : pc_plus4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (kind_q == K_LOAD) begin
                            rf_we   <= (rd_addr != 5'd0);
                            rf_wsel <= 1'b1;
                            state   <= S_WB;
                        end else begin
                            pc       <= pc_plus4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    rf_we    <= 1'b0;
                    rf_wsel  <= 1'b0;
                    pc       <= pc_plus4;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl_fsm.sv
// Scoreboard bench for exec_ctrl_fsm: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT raises strobes.
module tb_exec_ctrl_fsm;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func;
    logic        alu_b_sel;
    logic [31:0] imm;
    logic [31:0] alu_y;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rf_we;
    logic        rf_wsel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic        illegal;
    logic [31:0] pc;

    exec_ctrl_fsm #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .alu_func   (alu_func),
        .alu_b_sel  (alu_b_sel),
        .imm        (imm),
        .alu_y      (alu_y),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .illegal    (illegal),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum logic [2:0] {E_FETCH, E_EXEC, E_MEM, E_WB, E_ILL} ev_e;
    typedef struct {
        ev_e         kind;
        logic [31:0] a;
        logic [6:0]  opc;
        logic [2:0]  func;
        logic        flag;
        logic [4:0]  rd;
        logic        chk_rs;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t_ack    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t blank(input ev_e k);
        exp_t e;
        e.kind = k;   e.a = '0;      e.opc = '0;    e.func = '0;
        e.flag = 0;   e.rd = '0;     e.chk_rs = 0;  e.rs1 = '0;
        e.rs2 = '0;
        return e;
    endfunction

    task automatic pop_check(input ev_e k);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
            return;
        end
        e = q.pop_front();
        chk("event_kind", 32'(k), 32'(e.kind));
        if (k != e.kind) return;
        unique case (k)
            E_FETCH: chk("imem_addr", imem_addr, e.a);
            E_ILL:   chk("illegal_pc", pc, e.a);
            E_EXEC: begin
                chk("alu_opcode", 32'(alu_opcode), 32'(e.opc));
                chk("alu_func", 32'(alu_func), 32'(e.func));
                chk("alu_b_sel", 32'(alu_b_sel), 32'(e.flag));
                chk("imm", imm, e.a);
                if (e.chk_rs) begin
                    chk("rs1_addr", 32'(rs1_addr), 32'(e.rs1));
                    chk("rs2_addr", 32'(rs2_addr), 32'(e.rs2));
                end
            end
            E_MEM: begin
                chk("dmem_we", 32'(dmem_we), 32'(e.flag));
                chk("dmem_addr", dmem_addr, e.a);
            end
            E_WB: begin
                chk("rd_addr", 32'(rd_addr), 32'(e.rd));
                chk("rf_wsel", 32'(rf_wsel), 32'(e.flag));
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (illegal)             pop_check(E_ILL);
            if (imem_req && imem_ack) pop_check(E_FETCH);
            if (alu_en)              pop_check(E_EXEC);
            if (dmem_req && dmem_ack) pop_check(E_MEM);
            if (rf_we)               pop_check(E_WB);
        end
    end

    task automatic e_fetch(input logic [31:0] a);
        exp_t e = blank(E_FETCH);
        e.a = a;
        q.push_back(e);
    endtask

    task automatic e_exec(input logic [6:0] o, input logic [2:0] f,
                          input logic b, input logic [31:0] im);
        exp_t e = blank(E_EXEC);
        e.opc = o; e.func = f; e.flag = b; e.a = im;
        q.push_back(e);
    endtask

    task automatic e_exec_rs(input logic [6:0] o, input logic [2:0] f,
                             input logic [4:0] r1, input logic [4:0] r2);
        exp_t e = blank(E_EXEC);
        e.opc = o; e.func = f; e.chk_rs = 1; e.rs1 = r1; e.rs2 = r2;
        q.push_back(e);
    endtask

    task automatic e_mem(input logic we, input logic [31:0] a);
        exp_t e = blank(E_MEM);
        e.flag = we; e.a = a;
        q.push_back(e);
    endtask

    task automatic e_wb(input logic [4:0] rd, input logic wsel);
        exp_t e = blank(E_WB);
        e.rd = rd; e.flag = wsel;
        q.push_back(e);
    endtask

    task automatic e_ill(input logic [31:0] a);
        exp_t e = blank(E_ILL);
        e.a = a;
        q.push_back(e);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im,
        input logic [4:0] rs2, input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11],
                OP_BRANCH};
    endfunction

    task automatic wait_req(input bit spur, output bit ok);
        int n = 0;
        while (!imem_req && n < 50) begin
            if (spur) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hFFFF_FFFF;
                dmem_ack   = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        ok = imem_req;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL imem_req_timeout: got 0 expected 1");
        end
    endtask

    task automatic wait_dreq(output bit ok);
        int n = 0;
        while (!dmem_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = dmem_req;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL dmem_req_timeout: got 0 expected 1");
        end
    endtask

    task automatic do_fetch(input logic [31:0] instr);
        bit ok;
        wait_req(1'b0, ok);
        if (!ok) return;
        imem_rdata = instr;
        imem_ack   = 1'b1;
        t_ack      = cyc;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
    endtask

    task automatic do_mem(input int d);
        bit ok;
        wait_dreq(ok);
        if (!ok) return;
        repeat (d) begin
            @(posedge clk);
            #1;
        end
        chk("dmem_req_held", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
    endtask

    task automatic step(input logic [31:0] instr, input logic [31:0] y,
                        input bit mem, input int d, input int lat,
                        input bit spur);
        bit ok;
        alu_y = y;
        do_fetch(instr);
        if (mem) do_mem(d);
        wait_req(spur, ok);
        if (ok) chk("latency", 32'(cyc - t_ack), 32'(lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        alu_y      = '0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_pc", pc, RST_PC);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu_func", 32'(alu_func), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        rst_n = 1'b1;

        // add x3,x1,x2
        e_fetch(32'h100); e_exec_rs(OP_R, 3'b000, 5'd1, 5'd2); e_wb(5'd3, 0);
        step(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h55, 0, 0, 4, 0);
        chk("pc_after_add", pc, 32'h104);
        // sub x5,x6,x7
        e_fetch(32'h104); e_exec(OP_R, 3'b001, 0, 32'h0); e_wb(5'd5, 0);
        step(enc_r(7'h20, 5'd7, 5'd6, 3'b000, 5'd5), 32'h1, 0, 0, 4, 0);
        // srli x1,x1,4, with stray acks while not requesting
        e_fetch(32'h108); e_exec(OP_I, 3'b110, 1, 32'h4); e_wb(5'd1, 0);
        step(enc_i(12'h004, 5'd1, 3'b101, 5'd1, OP_I), 32'h2, 0, 0, 4, 1);
        // lw x4,-8(x2), dmem_ack after 3 wait cycles
        e_fetch(32'h10C); e_exec(OP_LOAD, 3'b000, 1, 32'hFFFF_FFF8);
        e_mem(0, 32'h2000_0010); e_wb(5'd4, 1);
        step(enc_i(12'hFF8, 5'd2, 3'b010, 5'd4, OP_LOAD), 32'h2000_0010,
             1, 3, 8, 0);
        // sw x5,12(x1)
        e_fetch(32'h110); e_exec(OP_STORE, 3'b000, 1, 32'hC);
        e_mem(1, 32'h1234);
        step(enc_s(12'h00C, 5'd5, 5'd1), 32'h1234, 1, 0, 4, 0);
        // beq taken 0x114 -> 0x40
        e_fetch(32'h114); e_exec(OP_BRANCH, 3'b001, 0, 32'hFFFF_FF2C);
        step(enc_b(13'h1F2C, 5'd2, 5'd1, 3'b000), 32'h0, 0, 0, 3, 0);
        // beq -16 taken at 0x40 -> 0x30
        e_fetch(32'h40); e_exec(OP_BRANCH, 3'b001, 0, 32'hFFFF_FFF0);
        step(enc_b(13'h1FF0, 5'd2, 5'd1, 3'b000), 32'h0, 0, 0, 3, 0);
        // bne +16 taken at 0x30 -> 0x40
        e_fetch(32'h30); e_exec(OP_BRANCH, 3'b001, 0, 32'h10);
        step(enc_b(13'h0010, 5'd2, 5'd1, 3'b001), 32'h1, 0, 0, 3, 0);
        // beq -16 not taken at 0x40 -> 0x44
        e_fetch(32'h40); e_exec(OP_BRANCH, 3'b001, 0, 32'hFFFF_FFF0);
        step(enc_b(13'h1FF0, 5'd2, 5'd1, 3'b000), 32'h5, 0, 0, 3, 0);
        // all-ones word is illegal
        e_fetch(32'h44); e_ill(32'h48);
        step(32'hFFFF_FFFF, 32'h0, 0, 0, 2, 0);
        // addi x0,x0,1: no writeback expected
        e_fetch(32'h48); e_exec(OP_I, 3'b000, 1, 32'h1);
        step(enc_i(12'h001, 5'd0, 3'b000, 5'd0, OP_I), 32'h1, 0, 0, 4, 0);
        // xori x7,x7,-1
        e_fetch(32'h4C); e_exec(OP_I, 3'b100, 1, 32'hFFFF_FFFF);
        e_wb(5'd7, 0);
        step(enc_i(12'hFFF, 5'd7, 3'b100, 5'd7, OP_I), 32'h0, 0, 0, 4, 0);
        // srai x1,x1,3 is illegal
        e_fetch(32'h50); e_ill(32'h54);
        step(enc_i(12'h403, 5'd1, 3'b101, 5'd1, OP_I), 32'h0, 0, 0, 2, 0);
        // lw x9,0(x0), zero-wait
        e_fetch(32'h54); e_exec(OP_LOAD, 3'b000, 1, 32'h0);
        e_mem(0, 32'h80); e_wb(5'd9, 1);
        step(enc_i(12'h000, 5'd0, 3'b010, 5'd9, OP_LOAD), 32'h80,
             1, 0, 5, 0);

        // lw interrupted by reset while waiting in MEM
        e_fetch(32'h58); e_exec(OP_LOAD, 3'b000, 1, 32'h4);
        alu_y = 32'h300;
        do_fetch(enc_i(12'h004, 5'd2, 3'b010, 5'd4, OP_LOAD));
        wait_dreq(ok);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_imem_req", 32'(imem_req), 32'd0);
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_queue", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // or x1,x2,x3 after reset
        e_fetch(32'h100); e_exec(OP_R, 3'b011, 0, 32'h0); e_wb(5'd1, 0);
        step(enc_r(7'h00, 5'd3, 5'd2, 3'b110, 5'd1), 32'h7, 0, 0, 4, 0);
        // beq x0,x0,-264: 0x104 -> 0xFFFF_FFFC
        e_fetch(32'h104); e_exec(OP_BRANCH, 3'b001, 0, 32'hFFFF_FEF8);
        step(enc_b(13'h1EF8, 5'd0, 5'd0, 3'b000), 32'h0, 0, 0, 3, 0);
        // add x2,x2,x2 at the top of memory; pc wraps to 0
        e_fetch(32'hFFFF_FFFC); e_exec(OP_R, 3'b000, 0, 32'h0); e_wb(5'd2, 0);
        step(enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd2), 32'h8, 0, 0, 4, 0);
        // and x8,x9,x10 at 0
        e_fetch(32'h0); e_exec(OP_R, 3'b010, 0, 32'h0); e_wb(5'd8, 0);
        step(enc_r(7'h00, 5'd10, 5'd9, 3'b111, 5'd8), 32'h3, 0, 0, 4, 0);

        chk("final_pc", pc, 32'h4);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl_fsm.md
Name: exec_ctrl_fsm

Overview:
Multi-cycle control FSM for the non-pipelined RISC-V core. It is the initiator side of the ALU interface.
- Fetches an instruction over a req/ack handshake and decodes it.
- Drives the ALU's enable, opcode and 3-bit function code, then sequences the memory and writeback steps.
- Owns the PC and sits between instruction memory, register file, ALU and data memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req  output  1  instruction fetch request, held until ack
imem_addr  output  32  fetch address (= pc)
imem_ack  input  1  fetch data valid this cycle
imem_rdata  input  32  instruction word
alu_en  output  1  ALU enable, high only in EXEC
alu_opcode  output  7  instruction opcode to ALU
alu_func  output  3  ALU op: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110
alu_b_sel  output  1  ALU B operand: 0 = rs2, 1 = imm
imm  output  32  sign-extended immediate
alu_y  input  32  ALU result
rs1_addr  output  5  register file read address 1
rs2_addr  output  5  register file read address 2
rd_addr  output  5  register file write address
rf_we  output  1  register write strobe (WB only)
rf_wsel  output  1  write data select: 0 = ALU result reg, 1 = load data
dmem_req  output  1  data memory request, held until ack
dmem_we  output  1  1 = store, 0 = load (valid with dmem_req)
dmem_addr  output  32  registered ALU result
dmem_ack  input  1  data access complete
illegal  output  1  one-cycle pulse on undecodable instruction
pc  output  32  current PC

Behaviour:
- Reset (async, rst_n = 0):
  - state = FETCH, pc = RESET_PC, IR = 0.
  - All strobes (imem_req, alu_en, rf_we, dmem_req, dmem_we, illegal) = 0; alu_func = 000; alu_opcode = 0; imm = 0; result reg = 0.
  - Reset mid-operation drops every request combinationally-from-flop within the reset assertion; no partial writeback.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - imem_req = 1. Stay while imem_ack = 0.
  - On imem_ack: IR <= imem_rdata, go to DECODE.
  - An ack in the first request cycle gives a 1-cycle fetch.
- DECODE (1 cycle):
  - IR fields drive rs1/rs2/rd.
  - imm: I-type sign-extends IR[31:20]. S-type sign-extends {IR[31:25], IR[11:7]}. B-type sign-extends {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - Function-code mapping:
    - R-type (0110011): funct3 000 with funct7 = 0000000 → ADD; with funct7 = 0100000 → SUB; 111 → AND; 110 → OR; 100 → XOR; 001 → SLL; 101 with funct7 = 0 → SRL.
    - I-type (0010011): same mapping without SUB. SLLI/SRLI require IR[31:25] = 0, and imm is replaced by zero-extended IR[24:20].
    - Load (0000011, funct3 010) and store (0100011, funct3 010): ADD with alu_b_sel = 1.
    - Branch (1100011, funct3 000 BEQ / 001 BNE): SUB with alu_b_sel = 0.
  - Anything else (incl. SRA/SRAI, other funct3) → illegal = 1 for one cycle, pc <= pc+4, go to FETCH; no rf_we, no dmem_req.
- EXEC (1 cycle):
  - alu_en = 1; alu_opcode/alu_func stable. Result reg <= alu_y at cycle end.
  - Next state: R/I → WB. L/S → MEM.
  - Branch: taken if (BEQ and alu_y == 0) or (BNE and alu_y != 0). Taken: pc <= pc + imm; else pc <= pc + 4. Then FETCH.
- MEM:
  - dmem_req = 1, dmem_we = (store), dmem_addr = result reg. Hold until dmem_ack.
  - On ack: load → WB (load data latched externally); store → pc+4, FETCH.
- WB (1 cycle):
  - rf_we = 1 unless rd_addr = 0 (x0 write suppressed). rf_wsel = 1 for loads.
  - pc <= pc+4, go to FETCH.
- Timing: alu_opcode/alu_func/alu_b_sel/imm are registered from DECODE onward and held constant through WB.
- Latency with zero-wait memories:
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles. Store: 4 cycles. Branch: 3 cycles.
- PC arithmetic is modulo 2^32 (wraps at 0xFFFF_FFFC+4 → 0).
- imem_ack or dmem_ack outside its request state is ignored.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (R/I/B/L/S types)
  - ALU func codes ADD..SRL
  - state enum {FETCH, DECODE, EXEC, MEM, WB}
  - funct7 constants
- One natural sub-module: imm_gen (combinational IR → imm per type), instanced in DECODE.

Test Plan:
- Reset then release with RESET_PC = 0x100, imem_ack immediate, IR = add x3,x1,x2 → imem_addr = 0x100; alu_en in cycle 3 with alu_func = 000, alu_opcode = 0110011; rf_we = 1 in cycle 4 with rd_addr = 3; pc = 0x104.
- IR = sub x5,x6,x7 (funct7 0100000) → alu_func = 001, alu_b_sel = 0. srli x1,x1,4 → alu_func = 110, imm = 4, alu_b_sel = 1.
- lw x4,-8(x2) with dmem_ack delayed 3 cycles → imm = 0xFFFF_FFF8; dmem_req held 4 cycles with dmem_we = 0; dmem_addr = alu_y; rf_wsel = 1, rf_we in WB; total 8 cycles.
- beq with alu_y = 0, imm = -16 at pc = 0x40 → pc = 0x30. Same with alu_y = 5 → pc = 0x44. No rf_we or dmem_req in either case.
- IR = 0xFFFF_FFFF → illegal pulses once in DECODE; pc += 4; no alu_en, rf_we or dmem_req. addi x0,x0,1 → rf_we stays 0.
- rst_n asserted during MEM with dmem_req high → dmem_req = 0 immediately; state = FETCH with pc = RESET_PC after release.
